// File: rtl/pio_in_edge_irq_pkg.sv
// -----------------------------------------------------------------------------
// pio_pkg
//
// Shared definitions for the input PIO slice:
//   - word addresses of the Avalon-MM register map
//   - edge_type_e, the kind of input transition latched into the capture
//     register (rising, falling or any)
//
// Imported by pio_in_edge_irq and pio_debounce_bit.
// -----------------------------------------------------------------------------
package pio_pkg;

    // Word addresses of the slave register map
    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
    localparam logic [1:0] ADDR_RESERVED = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    // Transition kind captured by the edge-capture register
    typedef enum logic [1:0] {
        RISE = 2'd0,
        FALL = 2'd1,
        ANY  = 2'd2
    } edge_type_e;

    // Picks the per-bit edge vector for the requested edge kind. Any
    // encoding outside the enum falls back to capturing both directions.
    function automatic logic [31:0] select_edge(
        input edge_type_e  kind,
        input logic [31:0] rise,
        input logic [31:0] fall
    );
        logic [31:0] result;
        result = rise | fall;
        case (kind)
            RISE:    result = rise;
            FALL:    result = fall;
            ANY:     result = rise | fall;
            default: result = rise | fall;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/pio_in_edge_irq_debounce.sv
// -----------------------------------------------------------------------------
// pio_debounce_bit
//
// Single-bit debounce filter for an already-synchronised input. The filtered
// output only follows the input after the input has disagreed with it for
// DEBOUNCE_CYCLES consecutive clocks; shorter excursions are discarded.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable-cycle count needed before filt_out changes (>= 1)
//
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   sync_in   in   synchronised input bit
//   filt_out  out  debounced bit
// -----------------------------------------------------------------------------
module pio_debounce_bit
    import pio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sync_in,
    output logic filt_out
);

    localparam int unsigned          CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] count;
    logic             filt;

    // The counter measures how long the input has disagreed with the filtered
    // value. Any cycle of agreement restarts the measurement, so a bounce
    // pulse never accumulates across separate glitches. On the last
    // disagreeing cycle the filtered value is updated and counting restarts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            filt  <= 1'b0;
        end else if (sync_in == filt) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            filt  <= sync_in;
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign filt_out = filt;

endmodule

// File: rtl/pio_in_edge_irq.sv
// -----------------------------------------------------------------------------
// pio_in_edge_irq
//
// Avalon-MM slave input PIO. Brings asynchronous board inputs (buttons,
// switches, HDMI hot-plug) into the clk domain, exposes the live value,
// latches selected edges into a sticky write-1-to-clear capture register and
// raises a maskable level interrupt.
//
// Register map (word addresses):
//   0 DATA          RO   synchronised (optionally debounced) input value
//   1 IRQ_MASK      RW   per-bit interrupt enable
//   2 reserved      reads 0, writes ignored
//   3 EDGE_CAPTURE  R/W1C sticky edge flags
//
// Parameters:
//   WIDTH            number of input bits (1..32)
//   EDGE_TYPE        0 = rising, 1 = falling, 2 = any
//   RESET_CAPTURE    reset value of the edge-capture register
//   DEBOUNCE_CYCLES  filter length, only used with PIO_IN_DEBOUNCE_EN
//
// Configuration macro:
//   PIO_IN_DEBOUNCE_EN  when defined, each input bit passes through a
//                       pio_debounce_bit filter after the synchroniser.
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   word address [1:0]
//   chipselect  in   slave select
//   read_n      in   read strobe, active-low
//   write_n     in   write strobe, active-low
//   writedata   in   write data [31:0]
//   readdata    out  read data [31:0], valid one cycle after the read strobe
//   in_port     in   asynchronous external inputs [WIDTH-1:0]
//   irq         out  level interrupt, active-high
// -----------------------------------------------------------------------------
module pio_in_edge_irq
    import pio_pkg::*;
#(
    parameter int unsigned           WIDTH           = 8,
    parameter int unsigned           EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0]      RESET_CAPTURE   = '0,
    parameter int unsigned           DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam edge_type_e EDGE_SEL = edge_type_e'(EDGE_TYPE[1:0]);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;

    logic             wr_stb;
    logic             rd_stb;

    logic [31:0]      rise_ext;
    logic [31:0]      fall_ext;
    logic [31:0]      edge_ext;
    logic [31:0]      din_ext;
    logic [31:0]      mask_ext;
    logic [31:0]      cap_ext;
    logic [31:0]      read_mux;

    // Only the low WIDTH bits of writedata carry meaning; the rest are
    // intentionally ignored.
    logic             unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_stb = chipselect & ~write_n;
    assign rd_stb = chipselect & ~read_n;

    // Two-flop synchroniser. in_port is fully asynchronous to clk, so sync1
    // may go metastable; only sync2 is consumed downstream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef PIO_IN_DEBOUNCE_EN
    // One independent filter per bit so a bouncing button cannot delay or
    // disturb its neighbours.
    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        pio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .reset_n  (reset_n),
            .sync_in  (sync2[i]),
            .filt_out (din[i])
        );
    end
`else
    assign din = sync2;
`endif

    // Previous input value for edge detection. Because prev and din both
    // restart at 0, leaving reset cannot fabricate an edge by itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
        end else begin
            prev <= din;
        end
    end

    // Edge detection and selection. The vectors are widened to 32 bits so a
    // single package helper can serve every WIDTH.
    always_comb begin
        rise     = din & ~prev;
        fall     = ~din & prev;
        rise_ext = '0;
        fall_ext = '0;
        rise_ext[WIDTH-1:0] = rise;
        fall_ext[WIDTH-1:0] = fall;
        edge_ext = select_edge(EDGE_SEL, rise_ext, fall_ext);
        edge_det = edge_ext[WIDTH-1:0];
    end

    // Write-1-to-clear vector for the capture register, active only during a
    // write strobe to EDGE_CAPTURE.
    always_comb begin
        clr = '0;
        if (wr_stb && (address == ADDR_EDGE_CAP)) begin
            clr = writedata[WIDTH-1:0];
        end
    end

    // Interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
        end else if (wr_stb && (address == ADDR_IRQ_MASK)) begin
            irq_mask <= writedata[WIDTH-1:0];
        end
    end

    // Sticky edge capture. A new edge is ORed in after the clear is applied,
    // so an edge arriving in the same cycle as a clear of that bit is kept
    // and software never loses an event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= RESET_CAPTURE;
        end else begin
            edge_capture <= edge_det | (edge_capture & ~clr);
        end
    end

    // Read multiplexer; registers narrower than 32 bits are zero-extended and
    // the reserved address reads as zero.
    always_comb begin
        din_ext  = '0;
        mask_ext = '0;
        cap_ext  = '0;
        din_ext[WIDTH-1:0]  = din;
        mask_ext[WIDTH-1:0] = irq_mask;
        cap_ext[WIDTH-1:0]  = edge_capture;
        read_mux = '0;
        case (address)
            ADDR_DATA:     read_mux = din_ext;
            ADDR_IRQ_MASK: read_mux = mask_ext;
            ADDR_RESERVED: read_mux = '0;
            ADDR_EDGE_CAP: read_mux = cap_ext;
            default:       read_mux = '0;
        endcase
    end

    // Registered read data with one cycle of latency. Between reads the last
    // value is held so the bus never sees spurious toggling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_stb) begin
            readdata <= read_mux;
        end
    end

    // The interrupt is a pure function of two registers, so it is glitch-free
    // and has no combinational path from any input port.
    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// -----------------------------------------------------------------------------
// tb_pio_in_edge_irq
//
// Self-checking bench for pio_in_edge_irq. Three instances share one Avalon
// bus (separate chipselects) and cover rising, falling and any-edge capture.
// Read expectations are queued when a read is issued and compared when the
// registered read data appears one cycle later.
//
// With PIO_IN_DEBOUNCE_EN defined, the debounce scenarios run instead of the
// unfiltered latency scenarios.
// -----------------------------------------------------------------------------
module tb_pio_in_edge_irq;

    import pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic [2:0]  cs;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_a, in_b, in_c;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        irq_a, irq_b, irq_c;

    typedef struct {
        string       tag;
        int          dut;
        logic [31:0] exp;
    } rd_exp_t;

    rd_exp_t sb[$];
    int      checks = 0;
    int      errors = 0;
    logic    rd_q   = 1'b0;

    always #5 clk = ~clk;

    pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(0), .RESET_CAPTURE(8'h00), .DEBOUNCE_CYCLES(16)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rd_a), .in_port(in_a), .irq(irq_a)
    );

    pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(1), .RESET_CAPTURE(8'h00), .DEBOUNCE_CYCLES(16)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rd_b), .in_port(in_b), .irq(irq_b)
    );

    pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(2), .RESET_CAPTURE(8'h00), .DEBOUNCE_CYCLES(16)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[2]),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rd_c), .in_port(in_c), .irq(irq_c)
    );

    // Counts every comparison and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives the external input of one instance
    task automatic applyStimulus(input int dut, input logic [7:0] value);
        case (dut)
            0:       in_a = value;
            1:       in_b = value;
            default: in_c = value;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle read; the expectation is queued for the monitor
    task automatic busRead(input int dut, input logic [1:0] addr, input logic [31:0] exp, input string tag);
        cs      = 3'(3'b001 << dut);
        address = addr;
        read_n  = 1'b0;
        sb.push_back('{tag: tag, dut: dut, exp: exp});
        @(negedge clk);
        cs      = 3'b000;
        read_n  = 1'b1;
    endtask

    task automatic busWrite(input int dut, input logic [1:0] addr, input logic [31:0] data);
        cs        = 3'(3'b001 << dut);
        address   = addr;
        writedata = data;
        write_n   = 1'b0;
        @(negedge clk);
        cs        = 3'b000;
        write_n   = 1'b1;
    endtask

    // Remember which cycles carried a read strobe
    always @(posedge clk) rd_q <= (|cs) && !read_n;

    // Read data is valid the cycle after the strobe; compare it here
    always @(negedge clk) begin : monitor
        rd_exp_t     e;
        logic [31:0] got;
        if (rd_q) begin
            if (sb.size() == 0) begin
                checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e   = sb.pop_front();
                got = (e.dut == 0) ? rd_a : (e.dut == 1) ? rd_b : rd_c;
                checkOutput(e.tag, got, e.exp);
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        address   = 2'd0;
        cs        = 3'b000;
        read_n    = 1'b1;
        write_n   = 1'b1;
        writedata = '0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        in_c      = 8'h00;
        idle(3);
        reset_n   = 1'b1;

        // Reset state
        busRead(0, ADDR_DATA,     32'h0, "rst_data");
        busRead(0, ADDR_IRQ_MASK, 32'h0, "rst_mask");
        busRead(0, ADDR_EDGE_CAP, 32'h0, "rst_cap");
        busRead(0, ADDR_RESERVED, 32'h0, "rst_resv");
        checkOutput("rst_irq", 32'(irq_a), 32'd0);

`ifdef PIO_IN_DEBOUNCE_EN
        // Short pulse is rejected
        applyStimulus(0, 8'h01);
        idle(10);
        applyStimulus(0, 8'h00);
        idle(25);
        busRead(0, ADDR_DATA,     32'h0, "db_short_data");
        busRead(0, ADDR_EDGE_CAP, 32'h0, "db_short_cap");

        // Long pulse passes after sync + DEBOUNCE_CYCLES
        applyStimulus(0, 8'h01);
        idle(17);
        busRead(0, ADDR_DATA, 32'h0, "db_long_early");
        busRead(0, ADDR_DATA, 32'h1, "db_long_data");
        idle(1);
        applyStimulus(0, 8'h00);
        idle(25);
        busRead(0, ADDR_EDGE_CAP, 32'h1, "db_long_cap");

        // Reset mid-count restarts the filter
        applyStimulus(0, 8'h01);
        idle(10);
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(17);
        busRead(0, ADDR_DATA, 32'h0, "db_rst_early");
        busRead(0, ADDR_DATA, 32'h1, "db_rst_data");
`else
        // Rising edge latency: DATA after k+1, capture after k+2
        applyStimulus(0, 8'h05);
        idle(1);
        busRead(0, ADDR_DATA,     32'h00, "rise_data_k1");
        busRead(0, ADDR_EDGE_CAP, 32'h00, "rise_cap_k2");
        busRead(0, ADDR_DATA,     32'h05, "rise_data");
        busRead(0, ADDR_EDGE_CAP, 32'h05, "rise_cap");
        checkOutput("irq_masked", 32'(irq_a), 32'd0);

        // Mask enables the interrupt on the next cycle
        busWrite(0, ADDR_IRQ_MASK, 32'h04);
        checkOutput("irq_on", 32'(irq_a), 32'd1);
        busRead(0, ADDR_IRQ_MASK, 32'h04, "mask_rd");
        busWrite(0, ADDR_EDGE_CAP, 32'h04);
        checkOutput("irq_clr", 32'(irq_a), 32'd0);
        busRead(0, ADDR_EDGE_CAP, 32'h01, "cap_clr4");
        busWrite(0, ADDR_EDGE_CAP, 32'hFF);
        busRead(0, ADDR_EDGE_CAP, 32'h00, "cap_clrall");

        // Edge on bit 1 coincides with a clear of bit 1
        applyStimulus(0, 8'h07);
        idle(2);
        busWrite(0, ADDR_EDGE_CAP, 32'h02);
        busRead(0, ADDR_EDGE_CAP, 32'h02, "set_wins");
        checkOutput("irq_unmasked_bit", 32'(irq_a), 32'd0);

        // Mask upper bits read as zero; irq follows the wider mask
        busWrite(0, ADDR_IRQ_MASK, 32'hFFFF_FFFF);
        busRead(0, ADDR_IRQ_MASK, 32'h0000_00FF, "mask_width");
        checkOutput("irq_bit1", 32'(irq_a), 32'd1);

        // Writes to DATA and the reserved word have no effect
        busWrite(0, ADDR_DATA, 32'h0000_0000);
        busRead(0, ADDR_DATA, 32'h07, "data_ro");
        busWrite(0, ADDR_RESERVED, 32'hFFFF_FFFF);
        busRead(0, ADDR_RESERVED, 32'h00, "resv_ro");

        // Falling-edge instance
        applyStimulus(1, 8'hFF);
        idle(3);
        busRead(1, ADDR_EDGE_CAP, 32'h00, "fall_none");
        busRead(1, ADDR_DATA,     32'hFF, "fall_data");
        applyStimulus(1, 8'hF0);
        idle(3);
        busRead(1, ADDR_EDGE_CAP, 32'h0F, "fall_cap");
        checkOutput("fall_irq", 32'(irq_b), 32'd0);

        // Any-edge instance: set once, stays set
        applyStimulus(2, 8'h01);
        idle(3);
        busRead(2, ADDR_EDGE_CAP, 32'h01, "any_rise");
        applyStimulus(2, 8'h00);
        idle(3);
        busRead(2, ADDR_EDGE_CAP, 32'h01, "any_sticky");
        busRead(2, ADDR_DATA,     32'h00, "any_data");
        busWrite(2, ADDR_EDGE_CAP, 32'h01);
        busRead(2, ADDR_EDGE_CAP, 32'h00, "any_clr");
        checkOutput("any_irq", 32'(irq_c), 32'd0);

        // Reset mid-operation with inputs held high
        idle(1);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_irq", 32'(irq_a), 32'd0);
        idle(2);
        reset_n = 1'b1;
        busRead(0, ADDR_EDGE_CAP, 32'h00, "midrst_cap");
        busRead(0, ADDR_IRQ_MASK, 32'h00, "midrst_mask");
        busRead(0, ADDR_EDGE_CAP, 32'h00, "midrst_cap_r3");
        busRead(0, ADDR_EDGE_CAP, 32'h07, "midrst_held_rise");
`endif

        idle(2);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
